// File: rtl/cu_seq_gen2_pkg.sv
// cu_seq_gen2 shared definitions: one-hot state encoding, opcode classes,
// and the opcode-to-class decoder.
package cu_seq_pkg;

  localparam int S_IDLE   = 0;
  localparam int S_FETCH  = 1;
  localparam int S_DECODE = 2;
  localparam int S_EXEC   = 3;
  localparam int S_MEM    = 4;
  localparam int S_WB     = 5;
  localparam int S_HALT   = 6;
  localparam int S_IRQ    = 7;

  typedef enum logic [7:0] {
    ST_IDLE   = 8'h01,
    ST_FETCH  = 8'h02,
    ST_DECODE = 8'h04,
    ST_EXEC   = 8'h08,
    ST_MEM    = 8'h10,
    ST_WB     = 8'h20,
    ST_HALT   = 8'h40,
    ST_IRQ    = 8'h80
  } state_t;

  typedef enum logic [2:0] {
    CLS_HALT = 3'd0,
    CLS_NOP  = 3'd1,
    CLS_ALU  = 3'd2,
    CLS_MEM  = 3'd3,
    CLS_STK  = 3'd4
  } cls_t;

  // Takes the top three opcode bits; spare codes fall back to ALU.
  function automatic cls_t op_class(input logic [2:0] hi);
    cls_t c;
    unique case (hi)
      3'd0:    c = CLS_HALT;
      3'd1:    c = CLS_NOP;
      3'd3:    c = CLS_MEM;
      3'd4:    c = CLS_STK;
      default: c = CLS_ALU;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cu_seq_gen2_fifo.sv
// cu_prefetch_fifo: circular opcode prefetch queue with flush.
// Flush wins over push and pop; a push while full is dropped.
module cu_prefetch_fifo #(
  parameter int OPW   = 6,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [OPW-1:0]           din,
  output logic [OPW-1:0]           dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [OPW-1:0] mem [DEPTH];
  logic [AW-1:0]  rp;
  logic [AW-1:0]  wp;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign dout    = mem[rp];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
    end else if (flush) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/cu_seq_gen2.sv
// cu_seq_gen2: prefetching one-hot control sequencer with execute watchdog.
// Interrupt entry state is built only when CU_SEQ_IRQ_EN is defined.
module cu_seq_gen2
  import cu_seq_pkg::*;
#(
  parameter int OPW   = 6,
  parameter int DEPTH = 4,
  parameter int TMO   = 255
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   li,
  input  logic [OPW-1:0]         opcode,
  output logic                   li_rdy,
  input  logic                   flush,
  input  logic                   ex,
  input  logic                   mem_done,
  input  logic                   irq,
  output logic                   irq_ack,
  output logic [OPW-1:0]         op_q,
  output logic [2:0]             cls,
  output logic                   exec_en,
  output logic                   mem_en,
  output logic                   wb_en,
  output logic [$clog2(DEPTH):0] count,
  output logic                   hlt,
  output logic                   err,
  output logic [7:0]             state
);

  state_t         st;
  cls_t           cur;
  logic [15:0]    tcnt;
  logic [OPW-1:0] head;
  logic           full;
  logic           empty;
  logic           q_flush;
  logic           pop;

  assign cur     = op_class(op_q[OPW-1 -: 3]);
  assign cls     = cur;
  assign state   = st;
  assign exec_en = st[S_EXEC];
  assign mem_en  = st[S_MEM];
  assign wb_en   = st[S_WB];
  assign hlt     = st[S_HALT];
  assign li_rdy  = ~full;

`ifdef CU_SEQ_IRQ_EN
  assign irq_ack = st[S_IRQ];
  assign q_flush = flush | st[S_IRQ];
`else
  logic irq_unused;
  assign irq_unused = irq;
  assign irq_ack    = 1'b0;
  assign q_flush    = flush;
`endif

  // A flush in the same cycle cancels the pop, so FETCH simply waits.
  assign pop = st[S_FETCH] & ~empty & ~q_flush;

  cu_prefetch_fifo #(
    .OPW   (OPW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_b (rst_b),
    .push  (li),
    .pop   (pop),
    .flush (q_flush),
    .din   (opcode),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      st   <= ST_IDLE;
      op_q <= '0;
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      unique case (1'b1)
        st[S_IDLE]: st <= ST_FETCH;
        st[S_FETCH]: begin
          if (pop) begin
            op_q <= head;
            st   <= ST_DECODE;
          end
        end
        st[S_DECODE]: begin
          unique case (cur)
            CLS_HALT: st <= ST_HALT;
            CLS_NOP:  st <= ST_FETCH;
            CLS_STK:  st <= ST_MEM;
            default: begin
              tcnt <= '0;
              st   <= ST_EXEC;
            end
          endcase
        end
        st[S_EXEC]: begin
          if (ex) begin
            st <= (cur == CLS_MEM) ? ST_MEM : ST_WB;
          end else if (tcnt == 16'(TMO - 1)) begin
            err <= 1'b1;
            st  <= ST_HALT;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        st[S_MEM]: begin
          if (mem_done) st <= ST_WB;
        end
        st[S_WB]: begin
`ifdef CU_SEQ_IRQ_EN
          st <= irq ? ST_IRQ : ST_FETCH;
`else
          st <= ST_FETCH;
`endif
        end
        st[S_HALT]: st <= ST_HALT;
        st[S_IRQ]:  st <= ST_FETCH;
        default:    st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cu_seq_gen2.sv
// Directed bench for cu_seq_gen2 (OPW=6, DEPTH=4, TMO=5).
// Per-cycle vector tables plus hand-written multi-cycle sequences.
module tb_cu_seq_gen2;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       li;
  logic [5:0] opcode;
  logic       li_rdy;
  logic       flush;
  logic       ex;
  logic       mem_done;
  logic       irq;
  logic       irq_ack;
  logic [5:0] op_q;
  logic [2:0] cls;
  logic       exec_en;
  logic       mem_en;
  logic       wb_en;
  logic [2:0] count;
  logic       hlt;
  logic       err;
  logic [7:0] state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cu_seq_gen2 #(
    .OPW   (6),
    .DEPTH (4),
    .TMO   (5)
  ) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .li       (li),
    .opcode   (opcode),
    .li_rdy   (li_rdy),
    .flush    (flush),
    .ex       (ex),
    .mem_done (mem_done),
    .irq      (irq),
    .irq_ack  (irq_ack),
    .op_q     (op_q),
    .cls      (cls),
    .exec_en  (exec_en),
    .mem_en   (mem_en),
    .wb_en    (wb_en),
    .count    (count),
    .hlt      (hlt),
    .err      (err),
    .state    (state)
  );

  typedef struct {
    logic       li;
    logic [5:0] opc;
    logic       ex;
    logic       md;
    logic       fl;
    logic [7:0] st;
    logic [2:0] cnt;
    logic       rdy;
    logic [3:0] en;
    logic [5:0] opq;
  } vec_t;

  vec_t run_a[$];
  vec_t run_b[$];

  function automatic vec_t mk(
    input logic li_i, input logic [5:0] opc_i,
    input logic ex_i, input logic md_i, input logic fl_i,
    input logic [7:0] st_i, input logic [2:0] cnt_i,
    input logic rdy_i, input logic [3:0] en_i,
    input logic [5:0] opq_i);
    vec_t v;
    v.li = li_i; v.opc = opc_i; v.ex = ex_i; v.md = md_i; v.fl = fl_i;
    v.st = st_i; v.cnt = cnt_i; v.rdy = rdy_i; v.en = en_i; v.opq = opq_i;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    li = 1'b0; opcode = '0; flush = 1'b0;
    ex = 1'b0; mem_done = 1'b0; irq = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_b = 1'b1;
  endtask

  task automatic run_tbl(input string name, input vec_t t[$]);
    foreach (t[i]) begin
      li = t[i].li; opcode = t[i].opc; ex = t[i].ex;
      mem_done = t[i].md; flush = t[i].fl;
      step();
      chk($sformatf("%s[%0d]", name, i),
          {state, count, li_rdy, exec_en, mem_en, wb_en, hlt, op_q},
          {t[i].st, t[i].cnt, t[i].rdy, t[i].en, t[i].opq});
    end
    idle_in();
  endtask

  logic [5:0] nops [3];
  logic [5:0] got[$];
  int         n;
  int         bad;

  initial begin
    // ALU instruction, then MEM instruction with delayed ex / mem_done.
    run_a.push_back(mk(1, 6'b010001, 0, 0, 0, 8'h02, 1, 1, 4'b0000, 6'b000000));
    run_a.push_back(mk(0, 6'b000000, 0, 0, 0, 8'h04, 0, 1, 4'b0000, 6'b010001));
    run_a.push_back(mk(0, 6'b000000, 0, 0, 0, 8'h08, 0, 1, 4'b1000, 6'b010001));
    run_a.push_back(mk(0, 6'b000000, 1, 0, 0, 8'h20, 0, 1, 4'b0010, 6'b010001));
    run_a.push_back(mk(0, 6'b000000, 0, 0, 0, 8'h02, 0, 1, 4'b0000, 6'b010001));
    run_a.push_back(mk(0, 6'b000000, 0, 0, 0, 8'h02, 0, 1, 4'b0000, 6'b010001));
    run_a.push_back(mk(1, 6'b011000, 0, 0, 0, 8'h02, 1, 1, 4'b0000, 6'b010001));
    run_a.push_back(mk(0, 6'b000000, 0, 0, 0, 8'h04, 0, 1, 4'b0000, 6'b011000));
    run_a.push_back(mk(0, 6'b000000, 0, 0, 0, 8'h08, 0, 1, 4'b1000, 6'b011000));
    run_a.push_back(mk(0, 6'b000000, 0, 0, 0, 8'h08, 0, 1, 4'b1000, 6'b011000));
    run_a.push_back(mk(0, 6'b000000, 0, 0, 0, 8'h08, 0, 1, 4'b1000, 6'b011000));
    run_a.push_back(mk(0, 6'b000000, 0, 0, 0, 8'h08, 0, 1, 4'b1000, 6'b011000));
    run_a.push_back(mk(0, 6'b000000, 1, 0, 0, 8'h10, 0, 1, 4'b0100, 6'b011000));
    run_a.push_back(mk(0, 6'b000000, 0, 0, 0, 8'h10, 0, 1, 4'b0100, 6'b011000));
    run_a.push_back(mk(0, 6'b000000, 0, 0, 0, 8'h10, 0, 1, 4'b0100, 6'b011000));
    run_a.push_back(mk(0, 6'b000000, 0, 1, 0, 8'h20, 0, 1, 4'b0010, 6'b011000));
    run_a.push_back(mk(0, 6'b000000, 0, 0, 0, 8'h02, 0, 1, 4'b0000, 6'b011000));

    // HALT at the head, then fill the queue, refused push, flushes.
    run_b.push_back(mk(1, 6'b000000, 0, 0, 0, 8'h02, 1, 1, 4'b0000, 6'b000000));
    run_b.push_back(mk(1, 6'b010001, 0, 0, 0, 8'h04, 1, 1, 4'b0000, 6'b000000));
    run_b.push_back(mk(1, 6'b011000, 0, 0, 0, 8'h40, 2, 1, 4'b0001, 6'b000000));
    run_b.push_back(mk(1, 6'b100000, 0, 0, 0, 8'h40, 3, 1, 4'b0001, 6'b000000));
    run_b.push_back(mk(1, 6'b001000, 0, 0, 0, 8'h40, 4, 0, 4'b0001, 6'b000000));
    run_b.push_back(mk(1, 6'b010101, 0, 0, 0, 8'h40, 4, 0, 4'b0001, 6'b000000));
    run_b.push_back(mk(1, 6'b010101, 0, 0, 1, 8'h40, 0, 1, 4'b0001, 6'b000000));
    run_b.push_back(mk(1, 6'b010101, 0, 0, 1, 8'h40, 0, 1, 4'b0001, 6'b000000));
    run_b.push_back(mk(1, 6'b010110, 0, 0, 0, 8'h40, 1, 1, 4'b0001, 6'b000000));
    run_b.push_back(mk(0, 6'b000000, 0, 0, 0, 8'h40, 1, 1, 4'b0001, 6'b000000));
    run_b.push_back(mk(0, 6'b000000, 0, 0, 0, 8'h40, 1, 1, 4'b0001, 6'b000000));

    nops[0] = 6'b001001;
    nops[1] = 6'b001010;
    nops[2] = 6'b001011;

    do_reset();
    chk("reset",
        {state, count, li_rdy, exec_en, mem_en, wb_en, hlt, err, irq_ack, op_q},
        {8'h01, 3'd0, 1'b1, 4'b0000, 1'b0, 1'b0, 6'd0});

    run_tbl("alu_mem", run_a);
    chk("alu_mem_err", {31'd0, err}, 32'd0);

    // Back-to-back NOPs wrap the pointers; check pop order.
    got.delete();
    for (int c = 0; c < 20; c++) begin
      if (c < 3) begin
        li = 1'b1; opcode = nops[c];
      end else begin
        li = 1'b0;
      end
      step();
      if (state == 8'h04) got.push_back(op_q);
    end
    idle_in();
    chk("nop_pops", got.size(), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("nop_op[%0d]", i),
          (i < got.size()) ? {26'd0, got[i]} : 32'hxxxxxxxx,
          {26'd0, nops[i]});

    // Interrupt request during WB.
    li = 1'b1; opcode = 6'b010011;
    step();
    li = 1'b0;
    n = 0;
    while (state != 8'h08 && n < 10) begin
      step(); n++;
    end
    chk("irq_reach_exec", state, 8'h08);
    ex = 1'b1;
    step();
    ex = 1'b0;
    chk("irq_wb", state, 8'h20);
    irq = 1'b1;
`ifdef CU_SEQ_IRQ_EN
    li = 1'b1; opcode = 6'b010100;
    step();
    li = 1'b0; irq = 1'b0;
    chk("irq_entry", {state, count, irq_ack}, {8'h80, 3'd1, 1'b1});
    step();
    chk("irq_exit", {state, count, irq_ack}, {8'h02, 3'd0, 1'b0});
`else
    step();
    irq = 1'b0;
    chk("irq_ignored", {state, irq_ack}, {8'h02, 1'b0});
    step();
    chk("irq_ignored2", {state, irq_ack}, {8'h02, 1'b0});
`endif

    do_reset();
    run_tbl("queue", run_b);

    // Watchdog: ALU opcode, ex never arrives.
    do_reset();
    li = 1'b1; opcode = 6'b010111;
    step();
    li = 1'b0;
    n = 0;
    while (state != 8'h08 && n < 10) begin
      step(); n++;
    end
    chk("tmo_reach_exec", {state, err}, {8'h08, 1'b0});
    n = 0;
    while (state == 8'h08 && n < 20) begin
      n++; step();
    end
    chk("tmo_exec_cycles", n, 5);
    chk("tmo_halt", {state, err, hlt, exec_en}, {8'h40, 1'b1, 1'b1, 1'b0});
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      ex = c[0]; mem_done = 1'b1;
      step();
      if (state !== 8'h40 || err !== 1'b1) bad++;
    end
    idle_in();
    chk("tmo_hold", bad, 0);

    // Asynchronous reset mid-instruction.
    do_reset();
    li = 1'b1; opcode = 6'b010001;
    step();
    opcode = 6'b010010;
    step();
    li = 1'b0;
    step();
    chk("mid_pre", {state, count}, {8'h08, 3'd1});
    #2;
    rst_b = 1'b0;
    #1;
    chk("mid_reset",
        {state, count, li_rdy, exec_en, err, op_q},
        {8'h01, 3'd0, 1'b1, 1'b0, 1'b0, 6'd0});
    #2;
    rst_b = 1'b1;
    step();
    step();
    chk("mid_after", {state, count}, {8'h02, 3'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cu_seq_gen2.md
# cu_seq_gen2

Second-generation control sequencer for the processor datapath. It buffers incoming opcodes in a small prefetch queue and decodes each opcode into an instruction class. A one-hot fetch/decode/execute/memory/write-back state machine then sequences the datapath enables from that class. Over the first-generation control unit it adds:
- parametrised opcode width and queue depth
- queue flush
- an execute-timeout watchdog with error flag
- an optional interrupt entry state

## Interface
Parameters:
- OPW, 6: opcode width. Minimum 3.
- DEPTH, 4: prefetch queue entries. Power of two, ≥ 2.
- TMO, 255: maximum EXEC cycles without `ex` before a timeout. Range 1..65535.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_b  in  1  reset, asynchronous, active-low.
- li  in  1  opcode valid; a push occurs when `li & li_rdy`.
- opcode  in  OPW  opcode to enqueue.
- li_rdy  out  1  queue not full, from the registered count.
- flush  in  1  discard all queued opcodes.
- ex  in  1  execute done, from the ALU.
- mem_done  in  1  memory access done.
- irq  in  1  interrupt request, level.
- irq_ack  out  1  interrupt taken, one-cycle pulse.
- op_q  out  OPW  current opcode register.
- cls  out  3  class of `op_q`.
- exec_en  out  1  high while in EXEC.
- mem_en  out  1  high while in MEM.
- wb_en  out  1  high while in WB.
- count  out  $clog2(DEPTH)+1  queue occupancy.
- hlt  out  1  high in HALT.
- err  out  1  sticky timeout flag.
- state  out  8  one-hot state vector.

## Operation
- Class is taken from `opcode[OPW-1:OPW-3]`:
  - 000 HALT
  - 001 NOP
  - 010 ALU
  - 011 MEM: execute, then memory access.
  - 100 STK: memory access only.
  - 101–111 ALU.
- State bits: 0 IDLE, 1 FETCH, 2 DECODE, 3 EXEC, 4 MEM, 5 WB, 6 HALT, 7 IRQ.
- IDLE → FETCH unconditionally.
- FETCH:
  - If `count != 0`: pop the head into `op_q` and go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - HALT → HALT.
  - NOP → FETCH.
  - STK → MEM.
  - ALU or MEM → EXEC. The timeout counter is cleared on this transition.
- EXEC:
  - On `ex`: class MEM → MEM; any other class → WB.
  - If the counter reaches TMO-1 with `ex` low: set `err` and go to HALT. Otherwise the counter increments.
- MEM → WB on `mem_done`; otherwise stay in MEM.
- WB → FETCH (or IRQ, see Configuration).
- HALT is absorbing. Only `rst_b` exits it.
- Queue:
  - Circular buffer with read and write pointers.
  - A simultaneous push and pop keeps `count` unchanged.
  - When full, a push is refused even if a pop occurs in the same cycle.
- `flush`:
  - Clears the pointers and `count` at the next edge.
  - Overrides any push and pop in that cycle.
  - Does not change state, and `op_q` is kept.

## Timing
- Reset values:
  - `state` = 8'b0000_0001 (IDLE).
  - `op_q` = 0, `count` = 0, `err` = 0.
  - `li_rdy` = 1.
  - `hlt`, `exec_en`, `mem_en`, `wb_en`, `irq_ack` all 0.
- All outputs are registered or decoded directly from registers. None depend combinationally on the inputs.
- ALU instruction with a non-empty queue and `ex` arriving on the first EXEC cycle: FETCH → DECODE → EXEC → WB → FETCH, 4 cycles.
- Timeout: `err` and `hlt` are asserted on the edge after the TMO-th EXEC cycle without `ex`.
- Asserting `rst_b` mid-instruction returns the block to IDLE immediately and empties the queue.

## Configuration
- Macro: `CU_SEQ_IRQ_EN`.
- When defined:
  - `irq` is sampled in WB. If high, the next state is IRQ instead of FETCH.
  - IRQ lasts one cycle. During it `irq_ack` = 1 and the queue is flushed; it then goes to FETCH.
- When undefined:
  - `irq` is ignored and `irq_ack` is tied to 0.
  - `state[7]` is never set and WB always goes to FETCH.

## Structure
- Package `cu_seq_pkg` holds:
  - the state index localparams (S_IDLE … S_IRQ)
  - the class codes (CLS_HALT … CLS_STK)
  - the function `op_class(opcode)`
- Sub-module `cu_prefetch_fifo` is parametrised by OPW and DEPTH. It provides push, pop, flush, count and full.
- The state machine, timeout counter and opcode register live in the top level.

## Test plan
- Reset, push 0b010001 (ALU), `ex` on the first EXEC cycle → state sequence 0x01, 0x02, 0x04, 0x08, 0x20, 0x02; `wb_en` high for 1 cycle; `op_q` = 0b010001.
- Push 0b011000 (MEM), `ex` after 3 cycles, `mem_done` after 2 cycles → EXEC held 4 cycles, MEM held 3 cycles, then WB.
- Hold the pop off (`ex` low), push 4 opcodes with DEPTH=4 → `count` = 4 and `li_rdy` = 0; a fifth push is refused; `flush` → `count` = 0 next cycle.
- TMO=5, ALU opcode with `ex` never asserted → after 5 EXEC cycles `err` = 1 and `hlt` = 1; state stays 0x40 for 100 cycles.
- Push 0b000000 (HALT) → `hlt` = 1 two cycles after FETCH; queued opcodes remain untouched.
- With `CU_SEQ_IRQ_EN`, `irq` high during WB → state 0x80 for one cycle, `irq_ack` = 1, `count` = 0, then FETCH.
